// File: rtl/mem_access_unit_if.sv
// Data-side SRAM-like bus between the memory-stage load/store unit and memory.
// Handshake: data_req/addr_ok accept a request; data_data_ok later completes it.
interface mem_access_unit_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: alignment check, one outstanding bus transaction,
// pipeline stall until completion, lane-aligned sign/zero-extended load result.
module mem_access_unit (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_valid,
  input  logic [7:0]          mem_op,
  input  logic [31:0]         mem_addr,
  input  logic [31:0]         mem_wdata,
  input  logic                flush_i,
  input  logic                stall_i,
  mem_access_unit_if.master   bus,
  output logic                stall_mem,
  output logic [31:0]         rdata_o,
  output logic                adel_o,
  output logic                ades_o,
  output logic [31:0]         badvaddr_o,
  output logic [1:0]          dbg_state
);

  localparam logic [7:0] OP_LB  = 8'hE0;
  localparam logic [7:0] OP_LH  = 8'hE1;
  localparam logic [7:0] OP_LW  = 8'hE3;
  localparam logic [7:0] OP_LBU = 8'hE4;
  localparam logic [7:0] OP_LHU = 8'hE5;
  localparam logic [7:0] OP_SB  = 8'hE8;
  localparam logic [7:0] OP_SH  = 8'hE9;
  localparam logic [7:0] OP_SW  = 8'hEB;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  logic [7:0]  op_q;
  logic [1:0]  lane_q;
  logic        discard;

  logic        is_load;
  logic        is_store;
  logic        is_half;
  logic        is_word;
  logic        misaligned;
  logic        start;
  logic [1:0]  size_d;
  logic [31:0] wdata_d;
  logic [31:0] load_ext;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_half  = 1'b0;
    is_word  = 1'b0;
    size_d   = 2'd0;
    wdata_d  = mem_wdata;
    case (mem_op)
      OP_LB, OP_LBU: is_load = 1'b1;
      OP_LH, OP_LHU: begin is_load = 1'b1; is_half = 1'b1; size_d = 2'd1; end
      OP_LW:         begin is_load = 1'b1; is_word = 1'b1; size_d = 2'd2; end
      OP_SB:         begin is_store = 1'b1; wdata_d = {4{mem_wdata[7:0]}}; end
      OP_SH:         begin is_store = 1'b1; is_half = 1'b1; size_d = 2'd1;
                           wdata_d = {2{mem_wdata[15:0]}}; end
      OP_SW:         begin is_store = 1'b1; is_word = 1'b1; size_d = 2'd2; end
      default:       ;
    endcase
  end

  assign misaligned = (is_half && mem_addr[0]) || (is_word && (mem_addr[1:0] != 2'b00));
  assign adel_o     = (state == IDLE) && mem_valid && is_load  && misaligned;
  assign ades_o     = (state == IDLE) && mem_valid && is_store && misaligned;
  assign badvaddr_o = mem_addr;
  assign start      = (state == IDLE) && mem_valid && (is_load || is_store)
                      && !misaligned && !flush_i;
  assign stall_mem  = start || (state == REQ) || (state == WAIT);
  assign dbg_state  = state;

  // Lane extraction uses the latched op/address, not the live pipeline inputs.
  always_comb begin
    byte_sel = bus.data_rdata[{lane_q, 3'b000} +: 8];
    half_sel = lane_q[1] ? bus.data_rdata[31:16] : bus.data_rdata[15:0];
    case (op_q)
      OP_LB:   load_ext = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_ext = {24'd0, byte_sel};
      OP_LH:   load_ext = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_ext = {16'd0, half_sel};
      OP_LW:   load_ext = bus.data_rdata;
      default: load_ext = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      op_q           <= 8'd0;
      lane_q         <= 2'd0;
      discard        <= 1'b0;
      rdata_o        <= 32'd0;
      bus.data_req   <= 1'b0;
      bus.data_wr    <= 1'b0;
      bus.data_size  <= 2'd0;
      bus.data_addr  <= 32'd0;
      bus.data_wdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q           <= mem_op;
            lane_q         <= mem_addr[1:0];
            discard        <= 1'b0;
            bus.data_req   <= 1'b1;
            bus.data_wr    <= is_store;
            bus.data_size  <= size_d;
            bus.data_addr  <= mem_addr;
            bus.data_wdata <= wdata_d;
            state          <= REQ;
          end
        end
        REQ: begin
          if (bus.data_addr_ok) begin
            // Once accepted the transaction must finish; a flush only drops its result.
            bus.data_req <= 1'b0;
            discard      <= flush_i;
            state        <= WAIT;
          end else if (flush_i) begin
            bus.data_req <= 1'b0;
            state        <= IDLE;
          end
        end
        WAIT: begin
          if (bus.data_data_ok) begin
            if (discard || flush_i) begin
              discard <= 1'b0;
              state   <= IDLE;
            end else begin
              rdata_o <= load_ext;
              state   <= DONE;
            end
          end else if (flush_i) begin
            discard <= 1'b1;
          end
        end
        DONE: begin
          if (flush_i || !stall_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: inputs change just after the falling edge,
// outputs are sampled 1 ns later, so registered values reflect the prior rising edge.
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        mem_valid;
  logic [7:0]  mem_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        flush_i;
  logic        stall_i;
  logic        stall_mem;
  logic [31:0] rdata_o;
  logic        adel_o;
  logic        ades_o;
  logic [31:0] badvaddr_o;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  logic        cap_wr;
  logic [1:0]  cap_size;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  int          stall_cnt;

  mem_access_unit_if bus ();

  mem_access_unit dut (
    .clk        (clk),
    .rst        (rst),
    .mem_valid  (mem_valid),
    .mem_op     (mem_op),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .flush_i    (flush_i),
    .stall_i    (stall_i),
    .bus        (bus.master),
    .stall_mem  (stall_mem),
    .rdata_o    (rdata_o),
    .adel_o     (adel_o),
    .ades_o     (ades_o),
    .badvaddr_o (badvaddr_o),
    .dbg_state  (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed no_finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // One transaction with immediate addr_ok and data_ok one cycle later.
  task automatic run_txn(input string tag, input logic [7:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input logic [31:0] exp_rdata);
    stall_cnt = 0;
    step();
    mem_valid = 1'b1; mem_op = op; mem_addr = addr; mem_wdata = wdata;
    #1;
    if (stall_mem) stall_cnt++;
    step();                           // REQ
    bus.data_addr_ok = 1'b1;
    #1;
    if (stall_mem) stall_cnt++;
    cap_wr = bus.data_wr; cap_size = bus.data_size;
    cap_addr = bus.data_addr; cap_wdata = bus.data_wdata;
    check({tag, "_req"}, {31'd0, bus.data_req}, 32'd1);
    step();                           // WAIT
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b1; bus.data_rdata = rdata;
    #1;
    if (stall_mem) stall_cnt++;
    step();                           // DONE
    bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
    mem_valid = 1'b0; stall_i = 1'b0;
    #1;
    if (stall_mem) stall_cnt++;
    check({tag, "_state_done"}, {30'd0, dbg_state}, 32'd3);
    check({tag, "_rdata"}, rdata_o, exp_rdata);
    check({tag, "_stall_cycles"}, stall_cnt, 32'd3);
    step();                           // back to IDLE
    #1;
    check({tag, "_state_idle"}, {30'd0, dbg_state}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; mem_valid = 1'b0; mem_op = 8'h00; mem_addr = 32'h0; mem_wdata = 32'h0;
    flush_i = 1'b0; stall_i = 1'b0;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
    #12;
    check("rst_req",   {31'd0, bus.data_req}, 32'd0);
    check("rst_wr",    {31'd0, bus.data_wr}, 32'd0);
    check("rst_size",  {30'd0, bus.data_size}, 32'd0);
    check("rst_addr",  bus.data_addr, 32'd0);
    check("rst_wdata", bus.data_wdata, 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    check("rst_stall", {31'd0, stall_mem}, 32'd0);
    step();
    rst = 1'b1;

    run_txn("lw",  8'hE3, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    check("lw_addr", cap_addr, 32'h0000_1004);
    check("lw_size", {30'd0, cap_size}, 32'd2);
    check("lw_wr",   {31'd0, cap_wr}, 32'd0);
    run_txn("lb",  8'hE0, 32'h0000_2003, 32'h0, 32'h80FF_FF7F, 32'hFFFF_FF80);
    check("lb_size", {30'd0, cap_size}, 32'd0);
    run_txn("lbu", 8'hE4, 32'h0000_2003, 32'h0, 32'h80FF_FF7F, 32'h0000_0080);
    run_txn("lh",  8'hE1, 32'h0000_2002, 32'h0, 32'h80FF_FF7F, 32'hFFFF_80FF);
    run_txn("lhu", 8'hE5, 32'h0000_2000, 32'h0, 32'h80FF_FF7F, 32'h0000_FF7F);

    // Flush while WAIT: result must be dropped and rdata_o keep the LHU value
    step();
    mem_valid = 1'b1; mem_op = 8'hE3; mem_addr = 32'h0000_4000;
    step();
    bus.data_addr_ok = 1'b1;
    step();
    bus.data_addr_ok = 1'b0; flush_i = 1'b1;
    #1;
    check("fl_wait_stall", {31'd0, stall_mem}, 32'd1);
    for (int i = 0; i < 2; i++) begin
      step();
      flush_i = 1'b0; mem_valid = 1'b0;
      #1;
      check("fl_hold_stall", {31'd0, stall_mem}, 32'd1);
      check("fl_hold_state", {30'd0, dbg_state}, 32'd2);
    end
    step();
    bus.data_data_ok = 1'b1; bus.data_rdata = 32'h1111_1111;
    #1;
    check("fl_dok_stall", {31'd0, stall_mem}, 32'd1);
    step();
    bus.data_data_ok = 1'b0;
    #1;
    check("fl_state_idle", {30'd0, dbg_state}, 32'd0);
    check("fl_rdata_kept", rdata_o, 32'h0000_FF7F);
    check("fl_stall_low",  {31'd0, stall_mem}, 32'd0);

    run_txn("sh", 8'hE9, 32'h0000_3002, 32'h1234_ABCD, 32'h5555_5555, 32'h0);
    check("sh_wr",    {31'd0, cap_wr}, 32'd1);
    check("sh_size",  {30'd0, cap_size}, 32'd1);
    check("sh_wdata", cap_wdata, 32'hABCD_ABCD);
    run_txn("sb", 8'hE8, 32'h0000_3001, 32'h0000_00A5, 32'h0, 32'h0);
    check("sb_wdata", cap_wdata, 32'hA5A5_A5A5);

    // Misaligned accesses
    step();
    mem_valid = 1'b1; mem_op = 8'hE3; mem_addr = 32'h0000_5002;
    #1;
    check("adel",       {31'd0, adel_o}, 32'd1);
    check("adel_ades",  {31'd0, ades_o}, 32'd0);
    check("adel_bva",   badvaddr_o, 32'h0000_5002);
    check("adel_stall", {31'd0, stall_mem}, 32'd0);
    step();
    #1;
    check("adel_noreq", {31'd0, bus.data_req}, 32'd0);
    check("adel_state", {30'd0, dbg_state}, 32'd0);
    mem_op = 8'hEB; mem_addr = 32'h0000_5001;
    #1;
    check("ades",       {31'd0, ades_o}, 32'd1);
    check("ades_adel",  {31'd0, adel_o}, 32'd0);
    check("ades_stall", {31'd0, stall_mem}, 32'd0);
    mem_op = 8'h20; mem_addr = 32'h0000_5000;
    #1;
    check("nonmem_stall", {31'd0, stall_mem}, 32'd0);
    step();
    #1;
    check("nonmem_noreq", {31'd0, bus.data_req}, 32'd0);

    // addr_ok withheld 4 cycles, then stall_i holds DONE
    step();
    mem_op = 8'hEB; mem_addr = 32'h0000_6008; mem_wdata = 32'hCAFE_F00D;
    for (int i = 0; i < 4; i++) begin
      step();
      #1;
      check("hold_req",   {31'd0, bus.data_req}, 32'd1);
      check("hold_addr",  bus.data_addr, 32'h0000_6008);
      check("hold_wdata", bus.data_wdata, 32'hCAFE_F00D);
      check("hold_stall", {31'd0, stall_mem}, 32'd1);
    end
    bus.data_addr_ok = 1'b1;
    step();
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h7777_7777;
    stall_i = 1'b1;
    step();
    bus.data_data_ok = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("done_hold_state", {30'd0, dbg_state}, 32'd3);
      check("done_hold_req",   {31'd0, bus.data_req}, 32'd0);
      check("done_hold_stall", {31'd0, stall_mem}, 32'd0);
      check("done_sw_rdata",   rdata_o, 32'h0);
      step();
    end
    stall_i = 1'b0; mem_valid = 1'b0;
    step();
    #1;
    check("done_release", {30'd0, dbg_state}, 32'd0);
    check("done_noreq",   {31'd0, bus.data_req}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
